// File: rtl/rvcpu_pkg.sv
// Shared RV64 pipeline definitions: opcodes, load/store funct3 encodings, MEM-stage state.
package rvcpu_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic legal_mem(input logic [6:0] opc, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (opc == OPC_LOAD) begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU: ok = 1'b1;
                default:                                            ok = 1'b0;
            endcase
        end else if (opc == OPC_STORE) begin
            case (f3)
                F3_SB, F3_SH, F3_SW, F3_SD: ok = 1'b1;
                default:                    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_data_align.sv
// Byte-lane steering for the MEM stage: store strobes/data, load extraction/extension.
// MEM_MISALIGN_TRAP_EN enables the misalignment flag; otherwise it is tied low.
module mem_data_align
    import rvcpu_pkg::*;
(
    input  logic [2:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [63:0] i_store_data,
    output logic [2:0]  o_addr_lo_aligned,
    output logic [7:0]  o_wstrb,
    output logic [63:0] o_wdata,
    output logic        o_misalign,
    input  logic [2:0]  i_ld_off,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_ld_data
);

    logic [2:0]  w_lo_mask;
    logic [7:0]  w_size_mask;
    logic [63:0] w_shifted;

    always_comb begin
        w_lo_mask   = 3'b111;
        w_size_mask = 8'h01;
        case (i_size)
            2'd0: begin w_lo_mask = 3'b111; w_size_mask = 8'h01; end
            2'd1: begin w_lo_mask = 3'b110; w_size_mask = 8'h03; end
            2'd2: begin w_lo_mask = 3'b100; w_size_mask = 8'h0F; end
            default: begin w_lo_mask = 3'b000; w_size_mask = 8'hFF; end
        endcase
    end

    // Low bits below the access size are dropped, so accesses align downward.
    assign o_addr_lo_aligned = i_addr_lo & w_lo_mask;
    assign o_wstrb           = w_size_mask << o_addr_lo_aligned;
    assign o_wdata           = i_store_data << {o_addr_lo_aligned, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    assign o_misalign = |(i_addr_lo & ~w_lo_mask);
`else
    assign o_misalign = 1'b0;
`endif

    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_size)
            2'd0: o_ld_data = i_ld_unsigned ? {56'd0, w_shifted[7:0]}
                                            : {{56{w_shifted[7]}}, w_shifted[7:0]};
            2'd1: o_ld_data = i_ld_unsigned ? {48'd0, w_shifted[15:0]}
                                            : {{48{w_shifted[15]}}, w_shifted[15:0]};
            2'd2: o_ld_data = i_ld_unsigned ? {32'd0, w_shifted[31:0]}
                                            : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/pipeline_mem_stage.sv
// RV64 memory-access stage: single-outstanding dmem port, timeout abort, registered WB result.
// Build option MEM_MISALIGN_TRAP_EN (in mem_data_align) traps misaligned loads/stores.
//   state | meaning
//   IDLE  | accept from EX; non-memory ops and traps complete in one cycle
//   BUSY  | request outstanding; waits for dmem_ready or timeout
module pipeline_mem_stage
    import rvcpu_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_MEM,
    input  logic [63:0] alu_result_MEM,
    input  logic [63:0] store_data_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [6:0]  opcode_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [63:0] pc_MEM,
    output logic        stall_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        valid_WB,
    output logic [63:0] result_WB,
    output logic [4:0]  rd_WB,
    output logic        reg_write_WB,
    output logic [63:0] pc_WB,
    output logic        bus_err_WB,
    output logic        misalign_WB
);

    localparam int TW = (DMEM_TIMEOUT < 1) ? 1 : $clog2(DMEM_TIMEOUT + 1);

    mem_state_t    r_state, w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [60:0]   r_addr_hi;
    logic [2:0]    r_off;
    logic [1:0]    r_size;
    logic          r_unsigned, r_we;
    logic [7:0]    r_wstrb;
    logic [63:0]   r_wdata, r_pc;
    logic [4:0]    r_rd;

    logic          w_is_store, w_legal, w_misalign, w_memop, w_trap;
    logic          w_accept, w_pass, w_timeout, w_done;
    logic [2:0]    w_off_al;
    logic [7:0]    w_wstrb;
    logic [63:0]   w_wdata, w_ld_data;

    assign w_is_store = (opcode_MEM == OPC_STORE);
    assign w_legal    = legal_mem(opcode_MEM, funct3_MEM);
    assign w_memop    = valid_MEM && w_legal && !w_misalign;
    assign w_trap     = valid_MEM && w_legal && w_misalign;
    assign w_accept   = (r_state == MEM_IDLE) && w_memop;
    assign w_pass     = (r_state == MEM_IDLE) && valid_MEM && !w_memop;
    assign w_timeout  = (r_state == MEM_BUSY) && (r_cnt == TW'(DMEM_TIMEOUT));
    assign w_done     = (r_state == MEM_BUSY) && dmem_ready && !w_timeout;

    mem_data_align u_align (
        .i_addr_lo         (alu_result_MEM[2:0]),
        .i_size            (funct3_MEM[1:0]),
        .i_store_data      (store_data_MEM),
        .o_addr_lo_aligned (w_off_al),
        .o_wstrb           (w_wstrb),
        .o_wdata           (w_wdata),
        .o_misalign        (w_misalign),
        .i_ld_off          (r_off),
        .i_ld_size         (r_size),
        .i_ld_unsigned     (r_unsigned),
        .i_rdata           (dmem_rdata),
        .o_ld_data         (w_ld_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= MEM_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MEM_IDLE: if (w_memop) w_state_nxt = MEM_BUSY;
            MEM_BUSY: if (dmem_ready || w_timeout) w_state_nxt = MEM_IDLE;
            default:  w_state_nxt = MEM_IDLE;
        endcase
    end

    always_comb begin
        dmem_req  = (r_state == MEM_BUSY) && !w_timeout;
        stall_MEM = ((r_state == MEM_IDLE) && w_memop) ||
                    ((r_state == MEM_BUSY) && !dmem_ready && !w_timeout);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_hi  <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wstrb    <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
        end else if (w_accept) begin
            r_addr_hi  <= alu_result_MEM[63:3];
            r_off      <= w_off_al;
            r_size     <= funct3_MEM[1:0];
            r_unsigned <= funct3_MEM[2];
            r_we       <= w_is_store;
            r_wstrb    <= w_is_store ? w_wstrb : 8'h00;
            r_wdata    <= w_is_store ? w_wdata : 64'd0;
            r_rd       <= rd_MEM;
            r_pc       <= pc_MEM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (w_accept)
            r_cnt <= '0;
        else if ((r_state == MEM_BUSY) && !dmem_ready && !w_timeout)
            r_cnt <= r_cnt + 1'b1;
    end

    assign dmem_addr  = {r_addr_hi, 3'b000};
    assign dmem_we    = r_we;
    assign dmem_wstrb = r_wstrb;
    assign dmem_wdata = r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_WB     <= 1'b0;
            result_WB    <= '0;
            rd_WB        <= '0;
            reg_write_WB <= 1'b0;
            pc_WB        <= '0;
            bus_err_WB   <= 1'b0;
            misalign_WB  <= 1'b0;
        end else begin
            valid_WB <= 1'b0;
            if (w_pass) begin
                valid_WB     <= 1'b1;
                result_WB    <= alu_result_MEM;
                rd_WB        <= rd_MEM;
                reg_write_WB <= writes_rd(opcode_MEM) && (rd_MEM != 5'd0);
                pc_WB        <= pc_MEM;
                bus_err_WB   <= 1'b0;
                misalign_WB  <= w_trap;
            end else if (w_done) begin
                valid_WB     <= 1'b1;
                result_WB    <= r_we ? 64'd0 : w_ld_data;
                rd_WB        <= r_rd;
                reg_write_WB <= !r_we && (r_rd != 5'd0);
                pc_WB        <= r_pc;
                bus_err_WB   <= 1'b0;
                misalign_WB  <= 1'b0;
            end else if (w_timeout) begin
                valid_WB     <= 1'b1;
                result_WB    <= 64'd0;
                rd_WB        <= r_rd;
                reg_write_WB <= 1'b0;
                pc_WB        <= r_pc;
                bus_err_WB   <= 1'b1;
                misalign_WB  <= 1'b0;
            end
        end
    end

endmodule
